// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM encoding, parity types,
// legal oversampling ratios and the majority-vote helper.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } rx_state_t;

   localparam logic PAR_EVEN = 1'b0;
   localparam logic PAR_ODD  = 1'b1;

   localparam logic [5:0] PRESC_8  = 6'd8;
   localparam logic [5:0] PRESC_16 = 6'd16;
   localparam logic [5:0] PRESC_32 = 6'd32;

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Captures the line at three mid-bit edges and registers their majority vote,
// which is stable from edge Prescale/2+2 until the end of the bit.
module uart_rx_sampler
   import uart_pkg::*;
#(
   parameter int PRESC_WIDTH = 6
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic                   i_rx_in,
   input  logic [PRESC_WIDTH-1:0] i_edge_cnt,
   input  logic [PRESC_WIDTH-1:0] i_prescale,
   output logic                   o_sampled_bit
);

   localparam logic [PRESC_WIDTH-1:0] EDGE_ONE = PRESC_WIDTH'(1);

   logic [PRESC_WIDTH-1:0] w_half;
   logic                   r_s0;
   logic                   r_s1;
   logic                   r_bit;

   assign w_half = i_prescale >> 1;

   // The third sample is voted directly from the line, so r_bit lands one edge later.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_s0  <= 1'b1;
         r_s1  <= 1'b1;
         r_bit <= 1'b1;
      end else begin
         if (i_edge_cnt == (w_half - EDGE_ONE)) begin
            r_s0 <= i_rx_in;
         end
         if (i_edge_cnt == w_half) begin
            r_s1 <= i_rx_in;
         end
         if (i_edge_cnt == (w_half + EDGE_ONE)) begin
            r_bit <= maj3(r_s0, r_s1, i_rx_in);
         end
      end
   end

   assign o_sampled_bit = r_bit;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start detection, LSB-first deserialisation, optional parity
// and stop checking, with single-cycle result pulses.
module uart_rx
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH  = 8,
   parameter int PRESC_WIDTH = 6
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic                   i_rx_in,
   input  logic [PRESC_WIDTH-1:0] i_prescale,
   input  logic                   i_par_en,
   input  logic                   i_par_typ,
   output logic [DATA_WIDTH-1:0]  o_p_data,
   output logic                   o_data_valid,
   output logic                   o_par_err,
   output logic                   o_stp_err
);

   localparam int BIT_W = $clog2(DATA_WIDTH + 3);
   localparam logic [PRESC_WIDTH-1:0] EDGE_ONE  = PRESC_WIDTH'(1);
   localparam logic [PRESC_WIDTH-1:0] EDGE_ZERO = PRESC_WIDTH'(0);
   localparam logic [BIT_W-1:0]       BIT_ONE   = BIT_W'(1);
   localparam logic [BIT_W-1:0]       BIT_ZERO  = BIT_W'(0);
   localparam logic [BIT_W-1:0]       LAST_DATA = BIT_W'(DATA_WIDTH);

   rx_state_t              r_state;
   logic [PRESC_WIDTH-1:0] r_edge_cnt;
   logic [PRESC_WIDTH-1:0] r_presc;
   logic [BIT_W-1:0]       r_bit_cnt;
   logic                   r_par_en;
   logic                   r_par_typ;
   logic                   r_frame_bad;
   logic [DATA_WIDTH-1:0]  r_shift;
   logic [DATA_WIDTH-1:0]  r_p_data;
   logic                   r_data_valid;
   logic                   r_par_err;
   logic                   r_stp_err;

   logic                   w_sampled_bit;
   logic                   w_last_edge;
   logic                   w_exp_par;

   uart_rx_sampler #(
      .PRESC_WIDTH (PRESC_WIDTH)
   ) u_sampler (
      .i_clk         (i_clk),
      .i_rst         (i_rst),
      .i_rx_in       (i_rx_in),
      .i_edge_cnt    (r_edge_cnt),
      .i_prescale    (r_presc),
      .o_sampled_bit (w_sampled_bit)
   );

   assign w_last_edge = (r_edge_cnt == (r_presc - EDGE_ONE));
   assign w_exp_par   = (^r_shift) ^ r_par_typ;

   // Frame FSM; the start-detect cycle is edge 0 of the start bit, so counting resumes at 1.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state      <= IDLE;
         r_edge_cnt   <= EDGE_ZERO;
         r_presc      <= PRESC_WIDTH'(0);
         r_bit_cnt    <= BIT_ZERO;
         r_par_en     <= 1'b0;
         r_par_typ    <= PAR_EVEN;
         r_frame_bad  <= 1'b0;
         r_shift      <= DATA_WIDTH'(0);
         r_p_data     <= DATA_WIDTH'(0);
         r_data_valid <= 1'b0;
         r_par_err    <= 1'b0;
         r_stp_err    <= 1'b0;
      end else begin
         r_data_valid <= 1'b0;
         r_par_err    <= 1'b0;
         r_stp_err    <= 1'b0;

         if (r_state != IDLE) begin
            if (w_last_edge) begin
               r_edge_cnt <= EDGE_ZERO;
               r_bit_cnt  <= r_bit_cnt + BIT_ONE;
            end else begin
               r_edge_cnt <= r_edge_cnt + EDGE_ONE;
            end
         end

         case (r_state)
            IDLE: begin
               if (!i_rx_in) begin
                  r_state     <= START;
                  r_edge_cnt  <= EDGE_ONE;
                  r_bit_cnt   <= BIT_ZERO;
                  r_presc     <= i_prescale;
                  r_par_en    <= i_par_en;
                  r_par_typ   <= i_par_typ;
                  r_frame_bad <= 1'b0;
               end else begin
                  r_edge_cnt <= EDGE_ZERO;
                  r_bit_cnt  <= BIT_ZERO;
               end
            end
            START: begin
               if (w_last_edge) begin
                  r_state <= w_sampled_bit ? IDLE : DATA;
               end
            end
            DATA: begin
               if (w_last_edge) begin
                  r_shift <= {w_sampled_bit, r_shift[DATA_WIDTH-1:1]};
                  if (r_bit_cnt == LAST_DATA) begin
                     r_state <= r_par_en ? PARITY : STOP;
                  end
               end
            end
            PARITY: begin
               if (w_last_edge) begin
                  if (w_sampled_bit != w_exp_par) begin
                     r_par_err   <= 1'b1;
                     r_frame_bad <= 1'b1;
                  end
                  r_state <= STOP;
               end
            end
            STOP: begin
               if (w_last_edge) begin
                  if (!w_sampled_bit) begin
                     r_stp_err <= 1'b1;
                  end else if (!r_frame_bad) begin
                     r_p_data     <= r_shift;
                     r_data_valid <= 1'b1;
                  end
                  // A low line here is the next start bit arriving with no idle gap.
                  if (!i_rx_in) begin
                     r_state     <= START;
                     r_edge_cnt  <= EDGE_ONE;
                     r_bit_cnt   <= BIT_ZERO;
                     r_presc     <= i_prescale;
                     r_par_en    <= i_par_en;
                     r_par_typ   <= i_par_typ;
                     r_frame_bad <= 1'b0;
                  end else begin
                     r_state <= IDLE;
                  end
               end
            end
            default: begin
               r_state    <= IDLE;
               r_edge_cnt <= EDGE_ZERO;
               r_bit_cnt  <= BIT_ZERO;
            end
         endcase
      end
   end

   assign o_p_data     = r_p_data;
   assign o_data_valid = r_data_valid;
   assign o_par_err    = r_par_err;
   assign o_stp_err    = r_stp_err;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: a table of single frames plus hand-written
// sequences for glitches, back-to-back frames, mid-frame reset and a stuck-low line.
module tb_uart_rx;

   logic       clk = 1'b0;
   logic       rst;
   logic       rx;
   logic [5:0] presc;
   logic       pen;
   logic       ptyp;
   logic [7:0] pdata;
   logic       dv;
   logic       perr;
   logic       serr;

   always #5 clk = ~clk;

   uart_rx #(
      .DATA_WIDTH  (8),
      .PRESC_WIDTH (6)
   ) dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_rx_in      (rx),
      .i_prescale   (presc),
      .i_par_en     (pen),
      .i_par_typ    (ptyp),
      .o_p_data     (pdata),
      .o_data_valid (dv),
      .o_par_err    (perr),
      .o_stp_err    (serr)
   );

   int total = 0;
   int bad   = 0;

   // Posedge index counter and pulse monitor (sampled on the falling edge).
   int         pcnt   = 0;
   int         dv_cnt = 0;
   int         pe_cnt = 0;
   int         se_cnt = 0;
   int         dv_cyc[$];
   logic [7:0] dv_dat[$];

   always @(posedge clk) pcnt <= pcnt + 1;

   always @(negedge clk) begin
      if (dv) begin
         dv_cnt <= dv_cnt + 1;
         dv_cyc.push_back(pcnt - 1);
         dv_dat.push_back(pdata);
      end
      if (perr) pe_cnt <= pe_cnt + 1;
      if (serr) se_cnt <= se_cnt + 1;
   end

   typedef struct {
      logic [7:0] d;
      int         p;
      logic       pen;
      logic       ptyp;
      logic       flip;
      logic       stopv;
      int         gbit;
      logic       chg;
      int         e_dv;
      int         e_pe;
      int         e_se;
      logic [7:0] e_pd;
   } vec_t;

   vec_t tab[8];

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   task automatic drive(input logic v, input int n);
      for (int c = 0; c < n; c++) begin
         @(negedge clk);
         rx = v;
      end
   endtask

   task automatic settle();
      @(posedge clk);
      #1;
   endtask

   // Drives one full frame; gbit inverts the mid sample of that frame bit, chg alters config after start.
   task automatic send_frame(input vec_t v, output int start_cyc);
      logic b[12];
      int   nb;
      nb    = 10 + int'(v.pen);
      presc = v.p[5:0];
      pen   = v.pen;
      ptyp  = v.ptyp;
      b[0]  = 1'b0;
      for (int i = 0; i < 8; i++) b[i+1] = v.d[i];
      if (v.pen) b[9] = (^v.d) ^ v.ptyp ^ v.flip;
      b[nb-1] = v.stopv;
      start_cyc = 0;
      for (int k = 0; k < nb; k++) begin
         for (int c = 0; c < v.p; c++) begin
            @(negedge clk);
            if (k == 0 && c == 0) start_cyc = pcnt;
            rx = (k == v.gbit && c == v.p / 2) ? ~b[k] : b[k];
            if (v.chg && k == 1 && c == 0) begin
               presc = 6'd8;
               pen   = ~v.pen;
               ptyp  = ~v.ptyp;
            end
         end
      end
   endtask

   task automatic run_vec(input vec_t v, input string tag);
      int b_dv, b_pe, b_se, q, st, nb;
      b_dv = dv_cnt;
      b_pe = pe_cnt;
      b_se = se_cnt;
      q    = dv_cyc.size();
      nb   = 10 + int'(v.pen);
      send_frame(v, st);
      drive(1'b1, 2 * v.p + 4);
      settle();
      chk({tag, "_dv_pulses"}, dv_cnt - b_dv, v.e_dv);
      chk({tag, "_par_err_pulses"}, pe_cnt - b_pe, v.e_pe);
      chk({tag, "_stp_err_pulses"}, se_cnt - b_se, v.e_se);
      chk({tag, "_p_data"}, int'(pdata), int'(v.e_pd));
      if (v.e_dv == 1 && dv_cyc.size() > q) begin
         chk({tag, "_latency"}, dv_cyc[q] - st, nb * v.p - 1);
         chk({tag, "_dv_data"}, int'(dv_dat[q]), int'(v.e_pd));
      end
   endtask

   initial begin
      vec_t v;
      int   b_dv, b_pe, b_se, q, s1, s2;

      //         d      p   pen   ptyp  flip  stop  gbit chg   dv pe se  pd
      tab[0] = '{8'hA5,  8, 1'b0, 1'b0, 1'b0, 1'b1, -1, 1'b0, 1, 0, 0, 8'hA5};
      tab[1] = '{8'h37, 16, 1'b1, 1'b0, 1'b1, 1'b1, -1, 1'b0, 0, 1, 0, 8'hA5};
      tab[2] = '{8'h37, 16, 1'b1, 1'b0, 1'b0, 1'b1, -1, 1'b1, 1, 0, 0, 8'h37};
      tab[3] = '{8'h00, 32, 1'b1, 1'b1, 1'b0, 1'b0, -1, 1'b0, 0, 0, 1, 8'h37};
      tab[4] = '{8'hC3, 16, 1'b0, 1'b0, 1'b0, 1'b1,  4, 1'b0, 1, 0, 0, 8'hC3};
      tab[5] = '{8'h81,  8, 1'b1, 1'b1, 1'b1, 1'b0, -1, 1'b0, 0, 1, 1, 8'hC3};
      tab[6] = '{8'h7E,  8, 1'b1, 1'b1, 1'b0, 1'b1, -1, 1'b0, 1, 0, 0, 8'h7E};
      tab[7] = '{8'hE7, 32, 1'b0, 1'b0, 1'b0, 1'b1,  9, 1'b0, 1, 0, 0, 8'hE7};

      rst   = 1'b1;
      rx    = 1'b1;
      presc = 6'd8;
      pen   = 1'b0;
      ptyp  = 1'b0;
      drive(1'b1, 3);
      settle();
      chk("reset_p_data", int'(pdata), 0);
      chk("reset_data_valid", int'(dv), 0);
      chk("reset_par_err", int'(perr), 0);
      chk("reset_stp_err", int'(serr), 0);
      @(negedge clk);
      rst = 1'b0;
      drive(1'b1, 5);

      for (int i = 0; i < 8; i++) begin
         run_vec(tab[i], $sformatf("vec%0d", i));
      end

      // Short start glitch at P=16 must be rejected silently.
      b_dv  = dv_cnt;
      b_pe  = pe_cnt;
      b_se  = se_cnt;
      presc = 6'd16;
      pen   = 1'b0;
      drive(1'b0, 3);
      drive(1'b1, 40);
      settle();
      chk("glitch_dv", dv_cnt - b_dv, 0);
      chk("glitch_errs", (pe_cnt - b_pe) + (se_cnt - b_se), 0);
      v = '{8'h5A, 16, 1'b0, 1'b0, 1'b0, 1'b1, -1, 1'b0, 1, 0, 0, 8'h5A};
      run_vec(v, "after_glitch");

      // Back-to-back frames with no idle gap.
      q = dv_cyc.size();
      b_dv = dv_cnt;
      v = '{8'h11, 8, 1'b0, 1'b0, 1'b0, 1'b1, -1, 1'b0, 1, 0, 0, 8'h11};
      send_frame(v, s1);
      v.d = 8'h22;
      send_frame(v, s2);
      drive(1'b1, 6);
      settle();
      chk("b2b_dv_count", dv_cnt - b_dv, 2);
      if (dv_cyc.size() >= q + 2) begin
         chk("b2b_first_data", int'(dv_dat[q]), 8'h11);
         chk("b2b_second_data", int'(dv_dat[q+1]), 8'h22);
         chk("b2b_spacing", dv_cyc[q+1] - dv_cyc[q], 80);
      end

      // Reset in the middle of the data bits of 0xFF.
      b_dv  = dv_cnt;
      b_pe  = pe_cnt;
      b_se  = se_cnt;
      presc = 6'd8;
      pen   = 1'b0;
      drive(1'b0, 8);
      drive(1'b1, 20);
      @(negedge clk);
      rst = 1'b1;
      settle();
      chk("midrst_p_data", int'(pdata), 0);
      chk("midrst_outputs", int'(dv) + int'(perr) + int'(serr), 0);
      @(negedge clk);
      rst = 1'b0;
      drive(1'b1, 60);
      settle();
      chk("midrst_no_pulses", (dv_cnt - b_dv) + (pe_cnt - b_pe) + (se_cnt - b_se), 0);
      v = '{8'h3C, 8, 1'b0, 1'b0, 1'b0, 1'b1, -1, 1'b0, 1, 0, 0, 8'h3C};
      run_vec(v, "after_rst");

      // Line stuck low: stp_err every 79 cycles, then recovery.
      b_dv  = dv_cnt;
      b_se  = se_cnt;
      presc = 6'd8;
      pen   = 1'b0;
      drive(1'b0, 238);
      drive(1'b1, 30);
      settle();
      chk("stuck_low_stp_err", se_cnt - b_se, 3);
      chk("stuck_low_dv", dv_cnt - b_dv, 0);
      v = '{8'h99, 8, 1'b0, 1'b0, 1'b0, 1'b1, -1, 1'b0, 1, 0, 0, 8'h99};
      run_vec(v, "after_stuck");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
